// File: rtl/final_adder_pkg.sv
// final_adder_pkg: shared float width, issue FSM encodings and float constants
package final_adder_pkg;
  localparam int FLOAT_W = 32;
  localparam int STATE_W = 2;
  localparam logic [FLOAT_W-1:0] FLOAT_ZERO = 32'h0000_0000;
  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = 2'b00,
    S_ISSUE     = 2'b01,
    S_WAIT_DONE = 2'b10
  } issue_state_e;
endpackage

// File: rtl/pair_fifo.sv
// pair_fifo: small synchronous FIFO holding {last, one, two} operand pairs
module pair_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  assign empty_o = wr_q == rd_q;
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rdata_o = mem_q[rd_q[AW-1:0]];
  // pointers carry one wrap bit so full and empty stay distinguishable
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i && !full_o) begin
        mem_q[wr_q[AW-1:0]] <= wdata_i;
        wr_q <= wr_q + 1'b1;
      end
      if (pop_i && !empty_o) rd_q <= rd_q + 1'b1;
    end
  end
endmodule

// File: rtl/pair_issuer.sv
// pair_issuer: pairs incoming float words and issues them one at a time to an accumulator
module pair_issuer
  import final_adder_pkg::*;
#(
  parameter int FLOAT_DATA_WIDTH = FLOAT_W,
  parameter int FIFO_DEPTH       = 4,
  parameter int STATE_WIDTH      = STATE_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clk_en,
  input  logic                        in_valid,
  input  logic [FLOAT_DATA_WIDTH-1:0] in_data,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic                        start,
  output logic [FLOAT_DATA_WIDTH-1:0] to_add_one,
  output logic [FLOAT_DATA_WIDTH-1:0] to_add_two,
  input  logic                        acc_working,
  input  logic                        acc_done,
  input  logic [FLOAT_DATA_WIDTH-1:0] acc_total,
  output logic [FLOAT_DATA_WIDTH-1:0] result,
  output logic                        result_valid,
  output logic                        busy,
  output logic                        protocol_err
);
  localparam int PW = 2 * FLOAT_DATA_WIDTH + 1;
  logic accept, push, pop, fifo_full, fifo_empty;
  logic [PW-1:0] push_data, pop_data;
  logic hold_valid_q;
  logic [FLOAT_DATA_WIDTH-1:0] hold_q;
  issue_state_e state_q;
  logic last_q, issued_q, start_q, result_valid_q, protocol_err_q;
  logic [FLOAT_DATA_WIDTH-1:0] one_q, two_q, result_q;
  assign in_ready  = clk_en && !fifo_full;
  assign accept    = in_valid && in_ready;
  assign push      = accept && (hold_valid_q || in_last);
  assign push_data = hold_valid_q ? {in_last, hold_q, in_data}
                                  : {1'b1, in_data, FLOAT_DATA_WIDTH'(FLOAT_ZERO)};
  assign pop       = clk_en && !fifo_empty && !acc_working && (state_q == S_IDLE);
  assign busy      = !fifo_empty || hold_valid_q || (STATE_WIDTH'(state_q) != STATE_WIDTH'(S_IDLE));
  assign start        = start_q;
  assign to_add_one   = one_q;
  assign to_add_two   = two_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign protocol_err = protocol_err_q;
  pair_fifo #(
    .WIDTH(PW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .pop_i  (pop),
    .wdata_i(push_data),
    .rdata_o(pop_data),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );
  // even words park in the hold register; an odd word or a last word drains it
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
    end else if (accept) begin
      hold_valid_q <= !hold_valid_q && !in_last;
      if (!hold_valid_q) hold_q <= in_data;
    end
  end
  // issue FSM: pop a pair, pulse start, then wait for the accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      start_q        <= 1'b0;
      result_valid_q <= 1'b0;
      protocol_err_q <= 1'b0;
      issued_q       <= 1'b0;
      last_q         <= 1'b0;
      one_q          <= '0;
      two_q          <= '0;
      result_q       <= '0;
    end else begin
      start_q        <= 1'b0;
      result_valid_q <= 1'b0;
      if (acc_done && issued_q && (state_q == S_IDLE || state_q == S_ISSUE)) protocol_err_q <= 1'b1;
      case (state_q)
        S_IDLE: if (pop) begin
          state_q                <= S_ISSUE;
          start_q                <= 1'b1;
          issued_q               <= 1'b1;
          {last_q, one_q, two_q} <= pop_data;
        end
        S_ISSUE: state_q <= S_WAIT_DONE;
        S_WAIT_DONE: if (acc_done) begin
          state_q <= S_IDLE;
          if (last_q) begin
            result_q       <= acc_total;
            result_valid_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pair_issuer.sv
// tb_pair_issuer: directed and random streams against a vector-level pairing/sum model
module tb_pair_issuer;
  logic clk = 0, rst = 1, clk_en = 0, in_valid = 0, in_last = 0;
  logic acc_working = 0, acc_done_r = 0, inj = 0;
  logic [31:0] in_data = 0, acc_total = 0;
  logic in_ready, start, result_valid, busy, protocol_err, acc_done;
  logic [31:0] to_add_one, to_add_two, result;
  int checks = 0, errors = 0;
  int lat = 2, cnt = 0, acc_sum = 0, starts = 0, dones = 0, start_viol = 0;
  bit stall = 0, pend = 0, prev_start = 0;
  logic [31:0] obs_one[$], obs_two[$], obs_res[$], exp_one[$], exp_two[$], exp_res[$];
  int vq[$];
  assign acc_done = acc_done_r | inj;
  always #5 clk = ~clk;
  pair_issuer dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .start(start), .to_add_one(to_add_one),
    .to_add_two(to_add_two), .acc_working(acc_working), .acc_done(acc_done),
    .acc_total(acc_total), .result(result), .result_valid(result_valid),
    .busy(busy), .protocol_err(protocol_err)
  );
  function automatic logic [31:0] i2f(input int v);
    int e;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    e = 0;
    for (int i = 0; i < 31; i++) if (v[i]) e = i;
    m = 32'(v) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction
  function automatic int f2i(input logic [31:0] f);
    int e;
    if (f[30:0] == 0) return 0;
    e = int'(f[30:23]) - 127;
    return int'({9'd1, f[22:0]} >> (23 - e));
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // accumulator model: integer-valued floats summed per vector, latency lat after start
  initial begin
    forever begin
      @(posedge clk); #2;
      acc_done_r = 0;
      if (result_valid) begin obs_res.push_back(result); acc_sum = 0; end
      if (start && (prev_start || pend)) start_viol++;
      prev_start = start;
      if (rst) begin
        pend = 0; acc_working = 0; acc_sum = 0;
      end else begin
        if (pend && !stall) begin
          if (cnt > 1) cnt--;
          else begin acc_done_r = 1; acc_total = i2f(acc_sum); pend = 0; acc_working = 0; dones++; end
        end
        if (start) begin
          starts++;
          obs_one.push_back(to_add_one);
          obs_two.push_back(to_add_two);
          acc_sum += f2i(to_add_one) + f2i(to_add_two);
          pend = 1; cnt = lat; acc_working = 1;
        end
      end
    end
  end
  task automatic send_word(input logic [31:0] d, input logic l);
    int n = 0;
    in_valid = 1; in_data = d; in_last = l;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    chk("accept_timeout", 32'(n < 200), 1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic send_vec(input int v[$], input bit gaps);
    int sum = 0;
    for (int i = 0; i < v.size(); i += 2) begin
      exp_one.push_back(i2f(v[i]));
      exp_two.push_back(i + 1 < v.size() ? i2f(v[i+1]) : 32'h0);
    end
    foreach (v[i]) sum += v[i];
    exp_res.push_back(i2f(sum));
    foreach (v[i]) begin
      send_word(i2f(v[i]), i == v.size() - 1);
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask
  task automatic wait_quiet(input string tag);
    int n = 0;
    while ((busy || pend || acc_working) && n < 500) begin @(posedge clk); #1; n++; end
    chk({tag, "_quiet"}, 32'(n < 500), 1);
    repeat (4) @(posedge clk);
    #1;
  endtask
  task automatic check_stream(input string tag);
    chk({tag, "_npairs"}, 32'(obs_one.size()), 32'(exp_one.size()));
    chk({tag, "_nres"}, 32'(obs_res.size()), 32'(exp_res.size()));
    while (obs_one.size() > 0 && exp_one.size() > 0) begin
      chk({tag, "_one"}, obs_one.pop_front(), exp_one.pop_front());
      chk({tag, "_two"}, obs_two.pop_front(), exp_two.pop_front());
    end
    while (obs_res.size() > 0 && exp_res.size() > 0)
      chk({tag, "_res"}, obs_res.pop_front(), exp_res.pop_front());
    obs_one.delete(); obs_two.delete(); obs_res.delete();
    exp_one.delete(); exp_two.delete(); exp_res.delete();
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int s0, d0, n, r0;
    clk_en = 1; rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_start", start, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_one", to_add_one, 0);
    chk("rst_two", to_add_two, 0);
    chk("rst_perr", protocol_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 1);
    lat = 2;
    vq = {1, 2, 3, 4};
    send_vec(vq, 0);
    wait_quiet("v4");
    chk("v4_result", result, 32'h4120_0000);
    chk("v4_starts", 32'(starts), 2);
    check_stream("v4");
    lat = 1;
    vq = {1, 2, 3};
    send_vec(vq, 0);
    wait_quiet("v3");
    chk("v3_result", result, 32'h40C0_0000);
    check_stream("v3");
    stall = 1; lat = 2; s0 = starts;
    vq = {1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    send_vec(vq, 0);
    chk("full_ready", in_ready, 0);
    chk("full_starts", 32'(starts - s0), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("full_ready_hold", in_ready, 0);
    chk("full_starts_hold", 32'(starts - s0), 1);
    stall = 0;
    wait_quiet("full");
    chk("full_result", result, i2f(55));
    check_stream("full");
    stall = 1; s0 = starts;
    vq = {5, 6, 7, 8};
    send_vec(vq, 0);
    n = 0;
    while (starts == s0 && n < 100) begin @(posedge clk); #1; n++; end
    chk("cen_first_issue", 32'(starts - s0), 1);
    clk_en = 0; s0 = starts; d0 = dones; stall = 0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("cen_ready", in_ready, 0);
    end
    chk("cen_no_start", 32'(starts - s0), 0);
    chk("cen_done", 32'(dones - d0), 1);
    clk_en = 1;
    wait_quiet("cen");
    check_stream("cen");
    for (int k = 0; k < 8; k++) begin
      int len;
      len = $urandom_range(1, 7);
      vq.delete();
      for (int i = 0; i < len; i++) vq.push_back(int'($urandom_range(1, 1000)));
      lat = $urandom_range(1, 4);
      send_vec(vq, 1);
    end
    wait_quiet("rand");
    check_stream("rand");
    chk("perr_before", protocol_err, 0);
    inj = 1;
    @(posedge clk); #1;
    inj = 0;
    chk("perr_set", protocol_err, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("perr_sticky", protocol_err, 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("perr_cleared", protocol_err, 0);
    stall = 1; s0 = starts;
    send_word(i2f(1), 0);
    send_word(i2f(2), 1);
    n = 0;
    while (starts == s0 && n < 100) begin @(posedge clk); #1; n++; end
    chk("mid_issue", 32'(starts - s0), 1);
    repeat (3) @(posedge clk);
    #1;
    r0 = obs_res.size();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    stall = 0;
    inj = 1;
    @(posedge clk); #1;
    inj = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_start", start, 0);
    chk("mid_result", result, 0);
    chk("mid_one", to_add_one, 0);
    chk("mid_two", to_add_two, 0);
    chk("mid_rv", result_valid, 0);
    chk("mid_perr", protocol_err, 0);
    chk("mid_busy", busy, 0);
    chk("mid_no_result", 32'(obs_res.size() - r0), 0);
    chk("start_protocol", 32'(start_viol), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pair_issuer.md
PAIR_ISSUER -- requirements
Module: pair_issuer

Interface
REQ-001 Parameter FLOAT_DATA_WIDTH, 32, IEEE-754 single word width.
REQ-002 Parameter FIFO_DEPTH, 4, pair-FIFO entries (power of two, >=2).
REQ-003 Parameter STATE_WIDTH, 2, issue FSM state width.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 clk_en  in  1  global advance enable for input acceptance and issue.
REQ-007 in_valid  in  1  upstream float word valid.
REQ-008 in_data  in  32  upstream float word.
REQ-009 in_last  in  1  marks final word of a vector.
REQ-010 in_ready  out  1  word accepted when in_valid && in_ready.
REQ-011 start  out  1  one-cycle issue pulse to accumulator stage.
REQ-012 to_add_one  out  32  first operand of issued pair.
REQ-013 to_add_two  out  32  second operand of issued pair.
REQ-014 acc_working  in  1  accumulator busy.
REQ-015 acc_done  in  1  accumulator one-cycle completion pulse.
REQ-016 acc_total  in  32  accumulator running total, valid with acc_done.
REQ-017 result  out  32  vector sum, held until next result.
REQ-018 result_valid  out  1  one-cycle pulse with new result.
REQ-019 busy  out  1  high when FIFO non-empty, hold register full, or FSM not IDLE.
REQ-020 protocol_err  out  1  sticky flag: unexpected acc_done.

Function
REQ-021 Accepted words SHALL alternate: even word into hold register, odd word forms pair {hold, in_data} pushed with last=in_last.
REQ-022 An in_last on an even word SHALL push pair {in_data, 32'h00000000} with last=1 and leave hold empty.
REQ-023 in_ready SHALL equal clk_en && !fifo_full; an even word is accepted without push and therefore also requires !fifo_full.
REQ-024 FSM states: IDLE(00), ISSUE(01), WAIT_DONE(10); 11 SHALL return to IDLE.
REQ-025 IDLE -> ISSUE when clk_en && !fifo_empty && !acc_working; FIFO pop on that edge, operands registered.
REQ-026 ISSUE: start=1 for exactly one cycle with to_add_one/to_add_two stable; next state WAIT_DONE.
REQ-027 to_add_one/to_add_two SHALL hold their value until the next issue.
REQ-028 WAIT_DONE: on acc_done go IDLE; if issued entry had last=1, result<=acc_total and result_valid=1 next cycle.
REQ-029 WAIT_DONE SHALL respond to acc_done regardless of clk_en.
REQ-030 At most one pair outstanding; start SHALL never assert outside ISSUE.
REQ-031 Simultaneous FIFO push and pop SHALL be permitted; count unchanged.
REQ-032 acc_done in IDLE or ISSUE after at least one issue since reset SHALL set protocol_err; cleared only by rst.
REQ-033 Issue-to-issue minimum spacing: 3 cycles plus accumulator latency.

Reset
REQ-034 rst SHALL clear FIFO, hold register, FSM to IDLE, start/result_valid/protocol_err to 0, result/to_add_one/to_add_two to 0.
REQ-035 rst mid-operation SHALL abandon outstanding pair; a late acc_done after reset SHALL NOT flag protocol_err (no issue since reset).

Structure
REQ-036 State encodings, FLOAT_DATA_WIDTH and float zero constant SHALL live in a shared final_adder package.
REQ-037 Pair storage SHALL be one sub-module pair_fifo (width 2*FLOAT_DATA_WIDTH+1, depth FIFO_DEPTH, full/empty flags).

Verification
REQ-038 Stream 1.0(3F800000),2.0(40000000),3.0(40400000),4.0(40800000,last) with model accumulator -> two start pulses, pairs (1.0,2.0),(3.0,4.0), result=41200000 (10.0) with one result_valid.
REQ-039 Stream 1.0,2.0,3.0(last) -> second pair (40400000,00000000), result=40C00000 (6.0).
REQ-040 Stall acc_done; push 10 words -> in_ready low once FIFO holds 4 pairs, no word lost, all pairs issued in order after release.
REQ-041 clk_en low 5 cycles with FIFO non-empty -> no start, in_ready low; WAIT_DONE still completes on acc_done.
REQ-042 Inject acc_done while IDLE after one issue -> protocol_err=1 until rst.
REQ-043 Assert rst during WAIT_DONE, then acc_done -> all outputs zero, protocol_err=0, no result_valid.
